// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI command-decoded burst RAM.
package spi_ram_pkg;

    // Opcode carried in the top two bits of every rx word.
    typedef enum logic [1:0] {
        OP_SET_WADDR = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SET_RADDR = 2'b10,
        OP_READ      = 2'b11
    } ram_op_e;

    // Burst engine states: IDLE waits for READ, FETCH reads one word, SEND offers it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_SEND  = 2'b10
    } burst_state_e;

    localparam int OP_W = 2;

endpackage

// File: rtl/ram_sp_rbw.sv
// Single-port-style RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old word.
module ram_sp_rbw #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Storage array has no reset so it can map onto block RAM.
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when re is low so the consumer sees a stable word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_ram_burst.sv
// Command-decoded RAM behind an SPI slave: address/write opcodes update the
// pointers and array every cycle; READ starts a burst handed out over tx_valid/tx_ready.
//
// Handshake: a beat transfers on a rising edge where tx_valid && tx_ready;
// while tx_valid is high and tx_ready low, tx_valid and dout do not change.
// rx_valid has no backpressure: every valid word is consumed on the edge it is seen.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 2**ADDR_W,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] din,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              cmd_err
);

    ram_op_e           op;
    logic [DATA_W-1:0] field;
    logic [ADDR_W-1:0] field_addr;

    burst_state_e      state, state_nxt;
    logic [DATA_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_wr, addr_rd;

    logic              read_req;
    logic              ram_we;
    logic              ram_re;

    // Wrap an address into the array range (no logic when MEM_DEPTH is a power of two).
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        return ADDR_W'(32'(a) % MEM_DEPTH);
    endfunction

    // Next sequential address with wrap at the top of the array.
    function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    assign op         = ram_op_e'(din[DATA_W+1:DATA_W]);
    assign field      = din[DATA_W-1:0];
    assign field_addr = wrap_addr(field[ADDR_W-1:0]);
    assign read_req   = rx_valid && (op == OP_READ);
    assign ram_we     = rx_valid && (op == OP_WRITE);
    assign busy       = (state != S_IDLE);

    ram_sp_rbw #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (addr_wr),
        .wdata (field),
        .re    (ram_re),
        .raddr (addr_rd),
        .rdata (dout)
    );

    // Burst state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst next-state and per-state outputs.
    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        tx_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (read_req) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                ram_re    = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_nxt = (cnt == '0) ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Remaining-beat counter: loaded with field (beats-1), stepped on each non-final accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == S_IDLE) && read_req) begin
            cnt <= field;
        end else if ((state == S_SEND) && tx_ready && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Write pointer: follows SET_WADDR in any state and optionally advances after each WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_wr <= '0;
        end else if (rx_valid && (op == OP_SET_WADDR)) begin
            addr_wr <= field_addr;
        end else if (ram_we && AUTO_INC) begin
            addr_wr <= inc_addr(addr_wr);
        end
    end

    // Read pointer: SET_RADDR only lands when idle; each fetch advances it so bursts chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_rd <= '0;
        end else if (rx_valid && (op == OP_SET_RADDR) && (state == S_IDLE)) begin
            addr_rd <= field_addr;
        end else if (state == S_FETCH) begin
            addr_rd <= inc_addr(addr_rd);
        end
    end

    // One-cycle error pulse for a READ that arrives while a burst is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= read_req && (state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: directed scenarios plus a randomized phase, checked
// by a scoreboard fed from a reference model of the command set.
module tb_spi_ram_burst;
    import spi_ram_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [DW+1:0] din = '0;
    logic          tx_ready = 1'b0;
    logic          tx_valid;
    logic [DW-1:0] dout;
    logic          busy;
    logic          cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [AW-1:0] m_wr = '0;
    logic [AW-1:0] m_rd = '0;
    logic [AW-1:0] burst_start = '0;
    int            burst_len = 0;
    int            beats_left = 0;
    logic          exp_err_next = 1'b0;
    logic          exp_err_cur = 1'b0;
    int            err_pulses = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_dout = '0;
    int            ready_mode = 0;   // 0: always ready, 1: random, 2: held low

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    spi_ram_burst #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .MEM_DEPTH (DEPTH),
        .AUTO_INC  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .din      (din),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .dout     (dout),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input ram_op_e op, input logic [DW-1:0] field);
        rx_valid = 1'b1;
        din      = {op, field};
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set_waddr(input logic [AW-1:0] a);
        m_wr = a;
        send(OP_SET_WADDR, a);
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        model_mem[m_wr] = d;
        m_wr = m_wr + 1'b1;
        send(OP_WRITE, d);
    endtask

    task automatic do_set_raddr(input logic [AW-1:0] a);
        if (beats_left == 0) m_rd = a;
        send(OP_SET_RADDR, a);
    endtask

    task automatic do_read(input logic [DW-1:0] n);
        logic [AW-1:0] idx;
        if (beats_left > 0) begin
            exp_err_next = 1'b1;
        end else begin
            for (int i = 0; i <= int'(n); i++) begin
                idx = m_rd + AW'(i);
                exp_q.push_back(model_mem[idx]);
            end
            burst_start = m_rd;
            burst_len   = int'(n) + 1;
            beats_left  = int'(n) + 1;
            m_rd        = m_rd + AW'(int'(n) + 1);
        end
        send(OP_READ, n);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        din      = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        beats_left   = 0;
        exp_err_next = 1'b0;
        exp_err_cur  = 1'b0;
        hold_prev    = 1'b0;
        m_wr         = '0;
        m_rd         = '0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((beats_left != 0 || exp_q.size() != 0) && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain", (beats_left == 0 && exp_q.size() == 0), 1);
        idle_cycle();
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 100 && got_q.size() < n; i++) idle_cycle();
        check("wait_beat", got_q.size() >= n, 1);
    endtask

    task automatic check_got(input string name, input int n, input logic [63:0] vals);
        check(name, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check(name, got_q[i], vals[8*i +: 8]);
        end
        got_q.delete();
    endtask

    // ---------------- tx_ready generator ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                check("cmd_err", cmd_err, exp_err_cur);
                if (cmd_err) err_pulses++;
                exp_err_cur  = exp_err_next;
                exp_err_next = 1'b0;
                if (hold_prev) begin
                    check("stall_valid", tx_valid, 1);
                    check("stall_dout", dout, prev_dout);
                end
                if (beats_left == 0) check("idle_tx_valid", tx_valid, 0);
                if (tx_valid && tx_ready) begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat", dout, e);
                    end
                    got_q.push_back(dout);
                    if (beats_left > 0) beats_left--;
                end
                hold_prev = tx_valid && !tx_ready;
                prev_dout = dout;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int r;
        int off;

        do_reset();
        do_reset();
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_err", cmd_err, 0);
        idle_cycle();

        // Single-beat read with latency check.
        ready_mode = 0;
        do_set_waddr(8'h10);
        do_write(8'hA5);
        do_set_raddr(8'h10);
        do_read(8'd0);
        @(negedge clk);
        check("lat_fetch_valid", tx_valid, 0);
        check("lat_fetch_busy", busy, 1);
        @(negedge clk);
        check("lat_send_valid", tx_valid, 1);
        check("lat_send_dout", dout, 8'hA5);
        wait_idle(50);
        check("busy_after", busy, 0);
        check_got("t1_beats", 1, 64'hA5);

        // Auto-increment across the top of the array, wrapped burst.
        do_set_waddr(8'hFE);
        do_write(8'h11);
        do_write(8'h22);
        do_write(8'h33);
        do_set_raddr(8'hFE);
        do_read(8'd2);
        wait_idle(50);
        check_got("t2_wrap", 3, 64'h33_22_11);

        // Stall on the second beat.
        do_set_waddr(8'h40);
        for (int i = 1; i <= 5; i++) do_write(8'hC0 + 8'(i));
        do_set_raddr(8'h40);
        do_read(8'd3);
        wait_got(1);
        ready_mode = 2;
        repeat (3) idle_cycle();
        ready_mode = 0;
        wait_idle(60);
        check_got("t3_stall", 4, 64'hC4_C3_C2_C1);

        // READ and SET_RADDR while busy.
        err_pulses = 0;
        do_set_raddr(8'h40);
        do_read(8'd3);
        do_read(8'd0);
        do_set_raddr(8'h10);
        wait_idle(60);
        repeat (2) idle_cycle();
        check("t4_err_pulses", err_pulses, 1);
        check_got("t4_beats", 4, 64'hC4_C3_C2_C1);
        do_read(8'd0);
        wait_idle(50);
        check_got("t4_continue", 1, 64'hC5);

        // Reset during a 5-beat burst.
        do_set_waddr(8'h60);
        for (int i = 1; i <= 5; i++) do_write(8'hD0 + 8'(i));
        do_set_raddr(8'h60);
        do_read(8'd4);
        wait_got(1);
        do_reset();
        @(negedge clk);
        check("t5_rst_valid", tx_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_beats_before_rst", got_q.size(), 1);
        got_q.delete();
        idle_cycle();
        do_set_raddr(8'h60);
        do_read(8'd4);
        wait_idle(60);
        check_got("t5_retained", 5, 64'hD5_D4_D3_D2_D1);

        // Write colliding with the fetch of the same address.
        do_set_waddr(8'h30);
        do_write(8'h5A);
        do_set_waddr(8'h30);
        do_set_raddr(8'h30);
        do_read(8'd0);
        do_write(8'h77);
        wait_idle(50);
        check_got("t6_old", 1, 64'h5A);
        do_set_raddr(8'h30);
        do_read(8'd0);
        wait_idle(50);
        check_got("t6_new", 1, 64'h77);

        // Randomized phase: fill the whole array, then mixed traffic.
        do_set_waddr(8'h00);
        for (int i = 0; i < DEPTH; i++) do_write(8'($urandom));
        ready_mode = 1;
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 9));
            if (beats_left == 0) begin
                if (r <= 2) begin
                    if ($urandom_range(0, 19) == 0) do_read(8'hFF);
                    else do_read(8'($urandom_range(0, 7)));
                end else if (r == 3) do_set_raddr(8'($urandom));
                else if (r == 4) do_set_waddr(8'($urandom));
                else if (r <= 7) do_write(8'($urandom));
                else idle_cycle();
            end else begin
                if (r == 0) do_read(8'($urandom_range(0, 7)));
                else if (r == 1) do_set_raddr(8'($urandom));
                else if (r <= 4) begin
                    off = int'(8'(m_wr - burst_start));
                    if (burst_len >= DEPTH) idle_cycle();
                    else if (off < burst_len)
                        do_set_waddr(8'(int'(burst_start) + burst_len +
                                        int'($urandom_range(0, DEPTH - 1 - burst_len))));
                    else do_write(8'($urandom));
                end else idle_cycle();
            end
        end
        wait_idle(3000);
        ready_mode = 0;
        repeat (3) idle_cycle();
        check("final_busy", busy, 0);
        check("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
